register_file: RTL and testbench
================================

# register_file

Integer register file for the RV32 core: 32 general-purpose registers of 32 bits each. It provides two asynchronous (combinational) read ports for rs1/rs2 operand fetch and one synchronous write port for writeback. Register x0 is hardwired to zero. The block sits between the decode stage (read addresses) and the writeback stage (write address/data/enable).

## Interface
Parameters:
- `DATA_WIDTH`, default 32, width of each register and of the data ports.
- `ADDR_WIDTH`, default 5, register address width; number of registers is 2**ADDR_WIDTH.

Ports:
- `clk`, input, 1, the single clock; all state updates occur on its rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `we`, input, 1, write enable for the write port.
- `wa`, input, ADDR_WIDTH, write address.
- `wd`, input, DATA_WIDTH, write data.
- `ra1`, input, ADDR_WIDTH, read address, port 1.
- `ra2`, input, ADDR_WIDTH, read address, port 2.
- `rd1`, output, DATA_WIDTH, read data, port 1.
- `rd2`, output, DATA_WIDTH, read data, port 2.

## Operation
- Storage: registers x1..x(2**ADDR_WIDTH−1). x0 has no storage and always reads 0.
- Write: on a rising `clk` edge with `we`=1 and `wa`≠0, register[wa] ← `wd`.
  - `we`=1 with `wa`=0 is silently ignored.
  - `we`=0 changes nothing, regardless of `wa` or `wd`.
- Read:
  - `rd1` = (`ra1`==0) ? 0 : register[ra1].
  - `rd2` = (`ra2`==0) ? 0 : register[ra2].
  - Both ports are purely combinational from the address and the stored state.
- Both read ports are fully independent. Both may address the same register, including x0 and including the register being written.
- Reset: `rst_n`=0 asynchronously clears every register to 0. While `rst_n` is low, writes are blocked.
- Outputs never carry X once reset has been applied. Every address is valid, so there are no out-of-range cases.

## Timing
- Write latency: 1 edge. Data written at edge N is visible on `rd1`/`rd2` immediately after edge N, within combinational settle time.
- No write-to-read bypass. If `ra` equals `wa` while a write is pending before the edge, the read returns the old value. The new value appears after the edge.
- Read latency: 0 cycles (combinational).
- Reset:
  - Assertion takes effect immediately, without waiting for a clock edge; `rd1`/`rd2` go to 0 for every address.
  - Deassertion is expected to be synchronized externally. The first write takes effect on the first rising edge with `rst_n`=1.
- Reset asserted on the same edge as a write: reset wins and the register stays 0.
- No handshake. A write is a single-cycle qualified strobe; back-to-back writes on consecutive edges are all committed.

## Structure
- The shared core package holds `XLEN` (32), `REG_ADDR_W` (5), `NUM_REGS` (32), and `reg_addr_t`/`word_t` typedefs. The parameter defaults derive from these.
- Single module:
  - storage array of `NUM_REGS`−1 words with async-reset flops;
  - a write-decode block (one-hot enable per register, x0 excluded);
  - two instances of the sub-module `regfile_read_port`, a parameterized read mux with zero-forcing for address 0.
- No latches and no memory macros; flop-based array only.

## Test plan
- Reset then read x0/x0 -> `rd1`=`rd2`=0x00000000. Read any x1..x31 after reset -> 0.
- `wa`=0, `wd`=0xDEADBEEF, `we`=1 for one edge; then read x0 on both ports -> 0x00000000.
- Write x1=0x11112222, then `we`=0; read `ra1`=1, `ra2`=0 -> `rd1`=0x11112222, `rd2`=0.
- Write x2=0x33334444; read `ra1`=1, `ra2`=2 -> 0x11112222 / 0x33334444. Read both ports at x2 -> 0x33334444 on both.
- `wa`=3, `wd`=0xFFFFFFFF, `we`=0 for one edge; read x3 -> 0x00000000.
- Sequence of ports and timing:
  - write x5=0xA5A5A5A5;
  - assert `rst_n`=0 mid-cycle -> `rd1`(x5) drops to 0 without a clock edge;
  - write on the edge during reset is ignored;
  - after release, write x5=0x5A5A5A5A -> read 0x5A5A5A5A.
  - Same-cycle read of `wa` before the edge returns the old value.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared core definitions for the RV32 integer register file.
package register_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One combinational read port: selects a register by address and forces
// zero for address 0 so x0 never depends on whatever sits in slot 0.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [ADDR_WIDTH-1:0]                         addr_i,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]    regs_i,
  output logic [DATA_WIDTH-1:0]                         data_o
);

  // Address-indexed mux with x0 zero-forcing
  always_comb begin
    data_o = '0;
    if (addr_i != '0) begin
      data_o = regs_i[addr_i];
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// RV32 integer register file: x1..x31 held in async-reset flops, x0 hardwired
// to zero, one synchronous write port and two independent combinational
// read ports. There is no write-to-read bypass: a read of the register being
// written returns the old value until the write edge.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  // One-hot write enables; slot 0 has no storage so it never gets an enable
  logic [NREGS-1:1]              wen_d;
  logic [DATA_WIDTH-1:0]         regs_q [NREGS-1:1];
  logic [NREGS-1:0][DATA_WIDTH-1:0] rf_view;

  // Write-address decode, qualified by the write enable
  always_comb begin
    wen_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      wen_d[i] = we && (wa == ADDR_WIDTH'(i));
    end
  end

  // Storage: each register clears on reset and loads wd when its enable is set
  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[g] <= '0;
      end else if (wen_d[g]) begin
        regs_q[g] <= wd;
      end
    end
  end

  // Flatten storage into a full-depth view with a constant zero in slot 0
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_port1 (
    .addr_i (ra1),
    .regs_i (rf_view),
    .data_o (rd1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_port2 (
    .addr_i (ra2),
    .regs_i (rf_view),
    .data_o (rd2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int pass_cnt;
  int total_cnt;

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; one write per rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0)
      $display("FAIL reset_x0 rd1=%h rd2=%h expected 00000000/00000000", rd1, rd2);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i + 1);
      #1;
      total_cnt++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0)
        $display("FAIL reset_x%0d rd1=%h rd2=%h expected 0", i, rd1, rd2);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_x0();
    do_write(5'd0, 32'hDEADBEEF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0)
      $display("FAIL write_x0_ignored rd1=%h rd2=%h expected 0", rd1, rd2);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_write(5'd1, 32'h11112222);
    ra1 = 5'd1; ra2 = 5'd0;
    #1;
    total_cnt++;
    if (rd1 !== 32'h11112222 || rd2 !== 32'h0)
      $display("FAIL write_x1 rd1=%h rd2=%h expected 11112222/00000000", rd1, rd2);
    else pass_cnt++;
  endtask

  task automatic test_two_ports();
    do_write(5'd2, 32'h33334444);
    ra1 = 5'd1; ra2 = 5'd2;
    #1;
    total_cnt++;
    if (rd1 !== 32'h11112222 || rd2 !== 32'h33334444)
      $display("FAIL two_ports rd1=%h rd2=%h expected 11112222/33334444", rd1, rd2);
    else pass_cnt++;
    ra1 = 5'd2; ra2 = 5'd2;
    #1;
    total_cnt++;
    if (rd1 !== 32'h33334444 || rd2 !== 32'h33334444)
      $display("FAIL same_addr rd1=%h rd2=%h expected 33334444/33334444", rd1, rd2);
    else pass_cnt++;
  endtask

  task automatic test_we_low();
    @(negedge clk);
    we = 1'b0; wa = 5'd3; wd = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    ra1 = 5'd3; ra2 = 5'd1;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0 || rd2 !== 32'h11112222)
      $display("FAIL we_low rd1=%h rd2=%h expected 00000000/11112222", rd1, rd2);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 32'hA5A5A5A5);
    ra1 = 5'd5; ra2 = 5'd2;
    #1;
    total_cnt++;
    if (rd1 !== 32'hA5A5A5A5)
      $display("FAIL pre_reset_x5 rd1=%h expected a5a5a5a5", rd1);
    else pass_cnt++;
    // Clock is low here; reset asserts with no edge nearby
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0)
      $display("FAIL async_clear rd1=%h rd2=%h expected 0", rd1, rd2);
    else pass_cnt++;
    we = 1'b1; wa = 5'd5; wd = 32'h12345678;
    @(posedge clk);
    #1;
    total_cnt++;
    if (rd1 !== 32'h0)
      $display("FAIL write_in_reset rd1=%h expected 00000000", rd1);
    else pass_cnt++;
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0)
      $display("FAIL post_release_x5 rd1=%h expected 00000000", rd1);
    else pass_cnt++;
    do_write(5'd5, 32'h5A5A5A5A);
    ra1 = 5'd5; ra2 = 5'd1;
    #1;
    total_cnt++;
    if (rd1 !== 32'h5A5A5A5A || rd2 !== 32'h0)
      $display("FAIL rewrite_x5 rd1=%h rd2=%h expected 5a5a5a5a/00000000", rd1, rd2);
    else pass_cnt++;
  endtask

  task automatic test_no_bypass();
    do_write(5'd7, 32'h0000AAAA);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h0000BBBB; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0000AAAA || rd2 !== 32'h0000AAAA)
      $display("FAIL no_bypass_old rd1=%h rd2=%h expected 0000aaaa", rd1, rd2);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (rd1 !== 32'h0000BBBB || rd2 !== 32'h0000BBBB)
      $display("FAIL no_bypass_new rd1=%h rd2=%h expected 0000bbbb", rd1, rd2);
    else pass_cnt++;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h10101010; exp_v[1] = 32'h20202020;
    exp_v[2] = 32'h30303030; exp_v[3] = 32'hFEDCBA98;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = 5'(28 + i); wd = exp_v[i];
      @(negedge clk);
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra1 = 5'(28 + i); ra2 = 5'(31 - i);
      #1;
      total_cnt++;
      if (rd1 !== exp_v[i] || rd2 !== exp_v[3 - i])
        $display("FAIL b2b_%0d rd1=%h rd2=%h expected %h/%h", i, rd1, rd2, exp_v[i], exp_v[3 - i]);
      else pass_cnt++;
    end
    // Earlier contents undisturbed
    ra1 = 5'd1; ra2 = 5'd2;
    #1;
    total_cnt++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0)
      $display("FAIL b2b_others rd1=%h rd2=%h expected 0 (cleared by reset)", rd1, rd2);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_write_x0();
    test_write_read();
    test_two_ports();
    test_we_low();
    test_async_reset();
    test_no_bypass();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_register_file
